// File: rtl/nic_output_flow_controller_pkg.sv
// Package: nic_output_flow_controller_pkg
// Shared types and helpers for the NoC output flow controller.
//  - state_e   : FSM state encoding (IDLE=00, REQUEST=01, ACTIVE=10)
//  - DEF_*     : default parameter values (4 data flits, 4 credits, 4 pending)
//  - clog2     : width helper, never returns less than 1 so that a
//                degenerate parameter (e.g. CREDITS=0) still gives a legal vector
package nic_output_flow_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    ACTIVE  = 2'b10
  } state_e;

  localparam int DEF_DATA_FLITS    = 4;
  localparam int DEF_CREDITS       = 4;
  localparam int DEF_PENDING_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nic_output_flow_controller_credit_counter.sv
// Module: nic_credit_counter
// Saturating up/down counter used for both router credits and queued
// done strobes.
//  Parameters: MAX (saturation value), W (counter width), INIT (reset value)
//  Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc, dec     one-cycle increment / decrement requests
//   count  [W]   current value
//   zero         count == 0
//   overflow     inc at MAX with no simultaneous dec (increment dropped)
module nic_credit_counter #(
  parameter int MAX  = 4,
  parameter int W    = 3,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         overflow
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // NOTE: sequential state is updated with non-blocking assignments so that
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(INIT);
    end else if (inc && !dec) begin
      if (count != MAX_V) count <= count + W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - W'(1);
    end
    // inc and dec together leave the count unchanged
  end

  assign zero     = (count == '0);
  assign overflow = inc && !dec && (count == MAX_V);

endmodule

// File: rtl/nic_output_flow_controller.sv
// Module: nic_output_flow_controller
// Output-side sequencer and credit-based flow controller for the NoC
// network interface. Queues packet-ready strobes, consumes one router
// credit per packet and walks the output-register selector through
// PKT_FLITS..1 for each packet, back-to-back when possible.
//  Parameters: DATA_FLITS, CREDITS, PENDING_DEPTH
//  Ports:
//   clk                   clock
//   reset                 asynchronous, active-low reset
//   credit_in_din         pulse: router returned one packet credit
//   done_strobe_din       pulse: node has one packet ready
//   zero_credits_dout     credit counter is empty
//   output_selector_dout  flit index being exposed, 0 when not sending
//   flit_valid_dout       selector is non-zero
//   busy_dout             FSM not idle or packets still queued
//   error_dout            sticky [0] credit overflow, [1] pending overflow
//  Optional feature: define NIC_OFC_STATS_EN to add pkt_sent_dout and
//  stall_cycles_dout statistics counters.
module nic_output_flow_controller
  import nic_output_flow_controller_pkg::*;
#(
  parameter int DATA_FLITS    = DEF_DATA_FLITS,
  parameter int CREDITS       = DEF_CREDITS,
  parameter int PENDING_DEPTH = DEF_PENDING_DEPTH,
  localparam int PKT_FLITS    = DATA_FLITS + 1,
  localparam int SEL_W        = clog2(PKT_FLITS + 1),
  localparam int CRT_W        = clog2(CREDITS + 1),
  localparam int PND_W        = clog2(PENDING_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             credit_in_din,
  input  logic             done_strobe_din,
  output logic             zero_credits_dout,
  output logic [SEL_W-1:0] output_selector_dout,
  output logic             flit_valid_dout,
  output logic             busy_dout,
  output logic [1:0]       error_dout
`ifdef NIC_OFC_STATS_EN
  ,
  output logic [15:0]      pkt_sent_dout,
  output logic [15:0]      stall_cycles_dout
`endif
);

  state_e             state, state_next;
  logic [SEL_W-1:0]   flit_cnt;
  logic [CRT_W-1:0]   credits;
  logic [PND_W-1:0]   pending;
  logic               credit_zero, pending_zero;
  logic               credit_ovf, pending_ovf;
  logic               start;
  logic               have_credit, have_pending, last_flit;

  assign have_credit  = (credits != '0);
  assign have_pending = (pending != '0);
  assign last_flit    = (flit_cnt == SEL_W'(1));

  // Router credits: one consumed per packet start, returned by the router.
  nic_credit_counter #(
    .MAX (CREDITS),
    .W   (CRT_W),
    .INIT(CREDITS)
  ) u_credit_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc     (credit_in_din),
    .dec     (start),
    .count   (credits),
    .zero    (credit_zero),
    .overflow(credit_ovf)
  );

  // Done strobes accepted but not yet started.
  nic_credit_counter #(
    .MAX (PENDING_DEPTH),
    .W   (PND_W),
    .INIT(0)
  ) u_pending_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc     (done_strobe_din),
    .dec     (start),
    .count   (pending),
    .zero    (pending_zero),
    .overflow(pending_ovf)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next state and packet-start decision
  // A packet starts from REQUEST, or on the last flit of the previous
  // packet so consecutive packets leave no gap cycle.
  // ---------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default at
  // the top so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (have_pending) state_next = REQUEST;
      end
      REQUEST: begin
        if (have_credit) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (last_flit) begin
          if (have_pending && have_credit) start      = 1'b1;
          else                             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    output_selector_dout = flit_cnt;
    flit_valid_dout      = (state == ACTIVE);
    busy_dout            = (state != IDLE) || !pending_zero;
    zero_credits_dout    = credit_zero;
  end

  // Flit counter: non-zero only while ACTIVE, so it drives the selector
  // directly; reset clears it immediately, aborting any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_cnt <= '0;
    end else if (start) begin
      flit_cnt <= SEL_W'(PKT_FLITS);
    end else if (state == ACTIVE && flit_cnt != '0) begin
      flit_cnt <= flit_cnt - SEL_W'(1);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) error_dout <= 2'b00;
    else        error_dout <= error_dout | {pending_ovf, credit_ovf};
  end

`ifdef NIC_OFC_STATS_EN
  // Packets started (wrapping) and cycles stalled in REQUEST for lack of
  // a credit (saturating).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_sent_dout     <= '0;
      stall_cycles_dout <= '0;
    end else begin
      if (start) pkt_sent_dout <= pkt_sent_dout + 16'd1;
      if (state == REQUEST && credit_zero && stall_cycles_dout != 16'hFFFF)
        stall_cycles_dout <= stall_cycles_dout + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nic_output_flow_controller.sv
// Testbench: tb_nic_output_flow_controller
// Drives directed scenarios and random strobe/credit traffic into
// nic_output_flow_controller (default parameters) and compares every
// cycle against a packet-level reference model held in integers.
// Define NIC_OFC_STATS_EN to also cover the statistics outputs.
module tb_nic_output_flow_controller;

  localparam int PKT    = 5;
  localparam int CRED   = 4;
  localparam int PDEPTH = 4;
  localparam int SEL_W  = 3;
`ifdef NIC_OFC_STATS_EN
  localparam int VW = 40;
`else
  localparam int VW = 8;
`endif

  logic             clk;
  logic             reset;
  logic             credit_in;
  logic             done_strobe;
  logic             zero_credits;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             busy;
  logic [1:0]       error;
`ifdef NIC_OFC_STATS_EN
  logic [15:0]      pkt_sent;
  logic [15:0]      stall_cycles;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: packet-level bookkeeping in plain integers.
  int       m_pend, m_cred, m_flits, m_pkt, m_stall;
  bit       m_req;      // a packet is waiting for a credit
  bit [1:0] m_err;

  nic_output_flow_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .credit_in_din       (credit_in),
    .done_strobe_din     (done_strobe),
    .zero_credits_dout   (zero_credits),
    .output_selector_dout(sel),
    .flit_valid_dout     (valid),
    .busy_dout           (busy),
`ifdef NIC_OFC_STATS_EN
    .pkt_sent_dout       (pkt_sent),
    .stall_cycles_dout   (stall_cycles),
`endif
    .error_dout          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 0; m_cred = CRED; m_flits = 0; m_req = 0;
    m_err = 2'b00; m_pkt = 0; m_stall = 0;
  endtask

  task automatic model_step(input bit s, input bit c);
    bit start;
    int np, nc;
    start = (m_req && m_cred > 0) || (m_flits == 1 && m_pend > 0 && m_cred > 0);
    np = m_pend + int'(s) - int'(start);
    if (np > PDEPTH) begin np = PDEPTH; m_err[1] = 1'b1; end
    nc = m_cred + int'(c) - int'(start);
    if (nc > CRED) begin nc = CRED; m_err[0] = 1'b1; end
    if (start) m_pkt = (m_pkt + 1) % 65536;
    if (m_req && m_cred == 0 && m_stall < 65535) m_stall++;
    if (start) m_req = 0;
    else if (m_flits == 0 && !m_req && m_pend > 0) m_req = 1;
    if (start) m_flits = PKT;
    else if (m_flits > 0) m_flits--;
    m_pend = np;
    m_cred = nc;
  endtask

  function automatic logic [VW-1:0] obs_vec();
    logic [VW-1:0] v;
    v = '0;
    v[7:0] = {zero_credits, sel, valid, busy, error};
`ifdef NIC_OFC_STATS_EN
    v[39:8] = {pkt_sent, stall_cycles};
`endif
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [VW-1:0] v;
    v = '0;
    v[7:0] = {m_cred == 0, SEL_W'(m_flits), m_flits != 0,
              (m_flits != 0 || m_req || m_pend != 0), m_err};
`ifdef NIC_OFC_STATS_EN
    v[39:8] = {16'(m_pkt), 16'(m_stall)};
`endif
    return v;
  endfunction

  // One clock: apply inputs, advance model at the edge, settle 1ns.
  task automatic step(input bit s, input bit c);
    done_strobe = s;
    credit_in   = c;
    @(posedge clk);
    model_step(s, c);
    #1;
    done_strobe = 1'b0;
    credit_in   = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0; done_strobe = 1'b0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs_vec() !== exp_vec() || {zero_credits, sel, valid, busy, error} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int exp_sel[8] = '{0, 0, 5, 4, 3, 2, 1, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec() || int'(sel) != exp_sel[i] || valid !== (exp_sel[i] != 0)) begin
        miscompares++;
        $display("FAIL single_pkt[%0d]: got %h sel %0d expected %h sel %0d",
                 i, obs_vec(), sel, exp_vec(), exp_sel[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, last, nvalid;
    first = -1; last = -1; nvalid = 0;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      step(i < 4, 1'b0);
      if (valid) begin
        if (first < 0) first = i;
        last = i;
        nvalid++;
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (nvalid != 20 || (last - first + 1) != 20) begin
      miscompares++;
      $display("FAIL b2b_contig: got %0d valid over span %0d expected 20 over 20",
               nvalid, last - first + 1);
    end
    // fifth packet with no credit left: stalls in REQUEST
    for (int i = 0; i < 6; i++) step(i == 0, 1'b0);
    vectors++;
    if (obs_vec() !== exp_vec() || zero_credits !== 1'b1 || busy !== 1'b1 || sel !== '0) begin
      miscompares++;
      $display("FAIL stall_hold: got %h expected %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec() || sel !== '0) begin
      miscompares++;
      $display("FAIL credit_release: got %h expected %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b0);
    vectors++;
    if (obs_vec() !== exp_vec() || sel !== SEL_W'(5)) begin
      miscompares++;
      $display("FAIL fifth_start: got sel %0d expected 5", sel);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
  endtask

  // Continues from back_to_back: credits are 0, FSM idle.
  task automatic test_pending_overflow();
    int starts;
    starts = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    vectors++;
    if (obs_vec() !== exp_vec() || error !== 2'b10) begin
      miscompares++;
      $display("FAIL pend_ovf: got %h err %b expected %h err 10", obs_vec(), error, exp_vec());
    end
    // six credits should release exactly the four retained packets
    for (int i = 0; i < 46; i++) begin
      step(1'b0, (i % 6 == 0) && (i < 36));
      if (sel == SEL_W'(5)) starts++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL pend_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (starts != 4) begin
      miscompares++;
      $display("FAIL pend_kept: got %0d packets expected 4", starts);
    end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);   // credit returned in the packet-start cycle
    vectors++;
    if (obs_vec() !== exp_vec() || sel !== SEL_W'(5) || error !== 2'b00) begin
      miscompares++;
      $display("FAIL credit_at_start: got %h expected %h", obs_vec(), exp_vec());
    end
    step(1'b0, 1'b1);   // count is back at 4, so this overflows
    vectors++;
    if (obs_vec() !== exp_vec() || error !== 2'b01) begin
      miscompares++;
      $display("FAIL credit_ovf: got err %b expected 01", error);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 5; i++) step(i == 0, 1'b0);   // selector now 3
    vectors++;
    if (sel !== SEL_W'(3)) begin
      miscompares++;
      $display("FAIL pre_abort: got sel %0d expected 3", sel);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (sel !== '0 || valid !== 1'b0 || busy !== 1'b0 || error !== 2'b00) begin
      miscompares++;
      $display("FAIL async_abort: got sel %0d valid %b busy %b expected 0 0 0", sel, valid, busy);
    end
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    step(1'b0, 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec() || error !== 2'b01) begin
      miscompares++;
      $display("FAIL credits_after_reset: got err %b expected 01", error);
    end
  endtask

`ifdef NIC_OFC_STATS_EN
  task automatic test_stats();
    do_reset();
    // drain all credits, then stall 7 cycles in REQUEST
    for (int i = 0; i < 30; i++) step(i < 4, 1'b0);
    for (int i = 0; i < 9; i++) step(i == 0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    vectors++;
    if (obs_vec() !== exp_vec() || pkt_sent !== 16'd5 || stall_cycles !== 16'd8) begin
      miscompares++;
      $display("FAIL stats: got pkt %0d stall %0d expected 5 8", pkt_sent, stall_cycles);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 22);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; done_strobe = 1'b0; credit_in = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_pending_overflow();
    test_credit_overflow();
    test_reset_mid_packet();
`ifdef NIC_OFC_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
